// File: rtl/fetch_queue.sv
// Instruction fetch queue: accepts fetch lines of up to IN_W instructions and
// hands them to decode one at a time from a circular buffer.
module fetch_queue #(
  parameter int XLEN  = 64,
  parameter int ILEN  = 32,
  parameter int DEPTH = 8,
  parameter int IN_W  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [IN_W*ILEN-1:0]         instr_i,
  input  logic [IN_W-1:0]              mask_i,
  input  logic [XLEN-1:0]              pc_i,
  input  logic                         pred_taken_i,
  input  logic [XLEN-1:0]              pred_target_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [ILEN-1:0]              instr_o,
  output logic [XLEN-1:0]              pc_o,
  output logic                         pred_taken_o,
  output logic [XLEN-1:0]              pred_target_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(IN_W+1);

  logic [ILEN-1:0] instr_q  [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic            pt_q     [DEPTH];
  logic [XLEN-1:0] tgt_q    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [NW-1:0] n_slots;
  logic          enq;
  logic          deq;
  logic [IN_W-1:0] wr_en;
  logic [IN_W-1:0] wr_last;
  logic [PW-1:0]   wr_idx [IN_W];

  always_comb begin
    n_slots = '0;
    for (int k = 0; k < IN_W; k++) begin
      n_slots = n_slots + NW'(mask_i[k]);
    end
  end

  // Readiness depends on registered occupancy only, so a dequeue in the same
  // cycle never opens room for an enqueue.
  assign ready_o = (CW'(DEPTH) - count_q) >= CW'(IN_W);
  assign valid_o = (count_q != '0);

  assign enq = valid_i && ready_o && !flush_i;
  assign deq = valid_o && ready_i && !flush_i;

  always_comb begin
    for (int k = 0; k < IN_W; k++) begin
      wr_idx[k]  = tail_q + PW'(k);
      wr_en[k]   = enq && (k < int'(n_slots));
      wr_last[k] = (k == int'(n_slots) - 1);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(n_slots);
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + (enq ? CW'(n_slots) : CW'(0)) - (deq ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Only the last valid slot of a line carries the branch prediction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        instr_q[e] <= '0;
        pc_q[e]    <= '0;
        pt_q[e]    <= 1'b0;
        tgt_q[e]   <= '0;
      end
    end else begin
      for (int k = 0; k < IN_W; k++) begin
        if (wr_en[k]) begin
          instr_q[wr_idx[k]] <= instr_i[k*ILEN +: ILEN];
          pc_q[wr_idx[k]]    <= pc_i + XLEN'(4*k);
          pt_q[wr_idx[k]]    <= wr_last[k] ? pred_taken_i : 1'b0;
          tgt_q[wr_idx[k]]   <= wr_last[k] ? pred_target_i : '0;
        end
      end
    end
  end

  assign instr_o       = instr_q[head_q];
  assign pc_o          = pc_q[head_q];
  assign pred_taken_o  = pt_q[head_q];
  assign pred_target_o = tgt_q[head_q];
  assign count_o       = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=8, IN_W=2, XLEN=64).
module tb_fetch_queue;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         valid_i;
  logic         ready_o;
  logic [63:0]  instr_i;
  logic [1:0]   mask_i;
  logic [63:0]  pc_i;
  logic         pred_taken_i;
  logic [63:0]  pred_target_i;
  logic         valid_o;
  logic         ready_i;
  logic [31:0]  instr_o;
  logic [63:0]  pc_o;
  logic         pred_taken_o;
  logic [63:0]  pred_target_o;
  logic [3:0]   count_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(8), .IN_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .instr_i(instr_i), .mask_i(mask_i), .pc_i(pc_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Masks must be contiguous from bit 0.
  always @(posedge clk_i) begin
    if (!rst_i && valid_i)
      assert ((mask_i & 2'(({1'b0, mask_i} + 3'd1))) == 2'b00)
        else $error("illegal non-contiguous mask %b", mask_i);
  end

  typedef struct {
    logic        fl, vl;
    logic [1:0]  msk;
    logic [63:0] ins, pc;
    logic        pt;
    logic [63:0] tgt;
    logic        rdy;
    logic [3:0]  e_cnt;
    logic        e_vo, e_ro;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic        e_pt;
    logic [63:0] e_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic vl, input logic [1:0] msk,
                     input logic [63:0] ins, input logic [63:0] pc, input logic pt,
                     input logic [63:0] tgt, input logic rdy, input logic [3:0] e_cnt,
                     input logic e_vo, input logic e_ro, input logic [63:0] e_pc,
                     input logic [31:0] e_ins, input logic e_pt, input logic [63:0] e_tgt);
    vec_t v;
    v.fl = fl; v.vl = vl; v.msk = msk; v.ins = ins; v.pc = pc; v.pt = pt;
    v.tgt = tgt; v.rdy = rdy; v.e_cnt = e_cnt; v.e_vo = e_vo; v.e_ro = e_ro;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_pt = e_pt; v.e_tgt = e_tgt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] cnt, input logic vo,
                           input logic ro, input logic [63:0] pc, input logic [31:0] ins,
                           input logic pt, input logic [63:0] tgt);
    check({tag, ".count"},  64'(count_o), 64'(cnt));
    check({tag, ".valid"},  64'(valid_o), 64'(vo));
    check({tag, ".ready"},  64'(ready_o), 64'(ro));
    check({tag, ".pc"},     pc_o, pc);
    check({tag, ".instr"},  64'(instr_o), 64'(ins));
    check({tag, ".pt"},     64'(pred_taken_o), 64'(pt));
    check({tag, ".target"}, pred_target_o, tgt);
  endtask

  task automatic drive(input logic fl, input logic vl, input logic [1:0] msk,
                       input logic [63:0] ins, input logic [63:0] pc, input logic pt,
                       input logic [63:0] tgt, input logic rdy);
    flush_i = fl; valid_i = vl; mask_i = msk; instr_i = ins; pc_i = pc;
    pred_taken_i = pt; pred_target_i = tgt; ready_i = rdy;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 2'b00, 64'h0, 64'h0, 0, 64'h0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check_out("reset", 4'd0, 0, 1, 64'h0, 32'h0, 0, 64'h0);
    rst_i = 1'b0;

    //   fl vl msk ins pc pt tgt rdy | cnt vo ro pc ins pt tgt
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h0,32'h0,0,64'h0);
    // enqueue and drain
    add(0,1,2'b11,64'h0000000B_0000000A,64'h1000,1,64'h2000,1, 2,1,1,64'h1000,32'hA,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  1,1,1,64'h1004,32'hB,1,64'h2000);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h0,32'h0,0,64'h0);
    // fill to full, head=2
    add(0,1,2'b11,64'h00000012_00000011,64'h100,0,64'h0,0,   2,1,1,64'h100,32'h11,0,64'h0);
    add(0,1,2'b11,64'h00000022_00000021,64'h200,1,64'h300,0, 4,1,1,64'h100,32'h11,0,64'h0);
    add(0,1,2'b11,64'h00000032_00000031,64'h400,0,64'h0,0,   6,1,1,64'h100,32'h11,0,64'h0);
    add(0,1,2'b11,64'h00000042_00000041,64'h500,1,64'h600,0, 8,1,0,64'h100,32'h11,0,64'h0);
    add(0,1,2'b11,64'h00000099_00000098,64'h700,1,64'h800,0, 8,1,0,64'h100,32'h11,0,64'h0);
    // drain the full queue in order
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  7,1,0,64'h104,32'h12,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  6,1,1,64'h200,32'h21,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  5,1,1,64'h204,32'h22,1,64'h300);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  4,1,1,64'h400,32'h31,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  3,1,1,64'h404,32'h32,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  2,1,1,64'h500,32'h41,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  1,1,1,64'h504,32'h42,1,64'h600);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h100,32'h11,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h100,32'h11,0,64'h0);
    // reach head=6, count=2
    add(0,1,2'b11,64'h00000052_00000051,64'h800,0,64'h0,0,   2,1,1,64'h800,32'h51,0,64'h0);
    add(0,1,2'b11,64'h00000054_00000053,64'h900,0,64'h0,0,   4,1,1,64'h800,32'h51,0,64'h0);
    add(0,1,2'b11,64'h00000062_00000061,64'hA00,1,64'hB00,0, 6,1,1,64'h800,32'h51,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  5,1,1,64'h804,32'h52,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  4,1,1,64'h900,32'h53,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  3,1,1,64'h904,32'h54,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  2,1,1,64'hA00,32'h61,0,64'h0);
    // concurrent enqueue/dequeue, new line wraps into entries 0 and 1
    add(0,1,2'b11,64'h00000072_00000071,64'hC00,1,64'hD00,1, 3,1,1,64'hA04,32'h62,1,64'hB00);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  2,1,1,64'hC00,32'h71,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  1,1,1,64'hC04,32'h72,1,64'hD00);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h800,32'h51,0,64'h0);
    // build count=5, then flush with a simultaneous push
    add(0,1,2'b11,64'h00000082_00000081,64'hE00,0,64'h0,0,   2,1,1,64'hE00,32'h81,0,64'h0);
    add(0,1,2'b11,64'h00000084_00000083,64'hE10,0,64'h0,0,   4,1,1,64'hE00,32'h81,0,64'h0);
    add(0,1,2'b01,64'h00000000_00000085,64'hE20,1,64'hE80,0, 5,1,1,64'hE00,32'h81,0,64'h0);
    add(1,1,2'b11,64'h00000092_00000091,64'hF00,1,64'hF80,1, 0,0,1,64'hC00,32'h71,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'hC00,32'h71,0,64'h0);
    // partial mask carries the prediction on slot 0
    add(0,1,2'b01,64'h00000000_000000A5,64'h40,1,64'h80,0,  1,1,1,64'h40,32'hA5,1,64'h80);
    // concurrent pushes walking tail to 7, then a line straddling 7 and 0
    add(0,1,2'b11,64'h000000B2_000000B1,64'h1100,0,64'h0,1,    2,1,1,64'h1100,32'hB1,0,64'h0);
    add(0,1,2'b11,64'h000000C2_000000C1,64'h1200,1,64'h1300,1, 3,1,1,64'h1104,32'hB2,0,64'h0);
    add(0,1,2'b11,64'h000000D2_000000D1,64'h1400,0,64'h0,1,    4,1,1,64'h1200,32'hC1,0,64'h0);
    add(0,1,2'b11,64'h000000E2_000000E1,64'hFFFF_FFFF_FFFF_FFFC,1,64'h1500,1,
        5,1,1,64'h1204,32'hC2,1,64'h1300);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  4,1,1,64'h1400,32'hD1,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  3,1,1,64'h1404,32'hD2,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  2,1,1,64'hFFFF_FFFF_FFFF_FFFC,32'hE1,0,64'h0);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  1,1,1,64'h0,32'hE2,1,64'h1500);
    add(0,0,2'b00,64'h0,64'h0,0,64'h0,1,  0,0,1,64'h1100,32'hB1,0,64'h0);
    // empty-mask line completes but writes nothing
    add(0,1,2'b00,64'h0000001F_0000001E,64'h5000,1,64'h6000,0, 0,0,1,64'h1100,32'hB1,0,64'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].vl, vecs[i].msk, vecs[i].ins, vecs[i].pc,
            vecs[i].pt, vecs[i].tgt, vecs[i].rdy);
      @(posedge clk_i);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_vo, vecs[i].e_ro,
                vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_pt, vecs[i].e_tgt);
    end

    // Asynchronous reset mid-operation discards entries immediately.
    drive(0, 1, 2'b11, 64'h00000002_00000001, 64'h3000, 1, 64'h3100, 0);
    @(posedge clk_i);
    #1;
    drive(0, 0, 2'b00, 64'h0, 64'h0, 0, 64'h0, 0);
    check("pre_rst.count", 64'(count_o), 64'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check_out("async_rst", 4'd0, 0, 1, 64'h0, 32'h0, 0, 64'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    drive(0, 1, 2'b01, 64'h00000000_00000077, 64'h2A00, 0, 64'h0, 0);
    @(posedge clk_i);
    #1;
    drive(0, 0, 2'b00, 64'h0, 64'h0, 0, 64'h0, 0);
    check_out("post_rst", 4'd1, 1, 1, 64'h2A00, 32'h77, 0, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
